// File: rtl/pulse_sched.sv
// Delay-sweep scheduler: steps the echo delay through npoints values, nshots periods each,
// applying new values only at period boundaries. Optional macro: PULSE_SCHED_BOUNDS_CHECK_EN.
module pulse_sched #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          clk_pll,
  input  logic          resetn,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_period,
  input  logic [W-1:0]  cfg_p1wid,
  input  logic [W-1:0]  cfg_delay,
  input  logic [W-1:0]  cfg_p2wid,
  input  logic [W-1:0]  cfg_step,
  input  logic [CW-1:0] cfg_npoints,
  input  logic [CW-1:0] cfg_nshots,
  input  logic          start,
  input  logic          abort,
  input  logic          cycle_end,
  output logic [W-1:0]  per,
  output logic [W-1:0]  p1wid,
  output logic [W-1:0]  del,
  output logic [W-1:0]  p2wid,
  output logic [CW-1:0] step_idx,
  output logic          running,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  state_t        r_state;
  logic [W-1:0]  r_sh_per, r_sh_p1, r_sh_del, r_sh_p2, r_sh_step;
  logic [CW-1:0] r_sh_np, r_sh_ns;
  logic          r_loaded;
  logic [CW-1:0] r_shot;
  logic [W-1:0]  r_per, r_p1, r_del, r_p2;
  logic [CW-1:0] r_step_idx;
  logic          r_running, r_done, r_err;

  logic          w_accept;
  logic [CW-1:0] w_np_eff, w_ns_eff, w_shot_inc;
  logic          w_shots_done, w_last;
  logic [W-1:0]  w_del_step;
  logic          w_ok0, w_ok_step;

  // Delay never wraps: carry out of the W+1-bit sum pins the result at all-ones.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

`ifdef PULSE_SCHED_BOUNDS_CHECK_EN
  function automatic logic pt_ok(input logic [W-1:0] p, input logic [W-1:0] w1,
                                 input logic [W-1:0] d, input logic [W-1:0] w2);
    return (w1 <= d) && (({1'b0, d} + {1'b0, w2}) <= {1'b0, p});
  endfunction
`endif

  assign w_accept     = cfg_valid && (r_state == S_IDLE);
  assign w_np_eff     = (r_sh_np == '0) ? CW'(1) : r_sh_np;
  assign w_ns_eff     = (r_sh_ns == '0) ? CW'(1) : r_sh_ns;
  assign w_shot_inc   = r_shot + CW'(1);
  assign w_shots_done = (w_shot_inc == w_ns_eff);
  assign w_last       = (r_step_idx == w_np_eff - CW'(1));
  assign w_del_step   = sat_add(r_del, r_sh_step);

`ifdef PULSE_SCHED_BOUNDS_CHECK_EN
  assign w_ok0     = pt_ok(r_sh_per, r_sh_p1, r_sh_del, r_sh_p2);
  assign w_ok_step = pt_ok(r_per, r_p1, w_del_step, r_p2);
`else
  assign w_ok0     = 1'b1;
  assign w_ok_step = 1'b1;
`endif

  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_loaded   <= 1'b0;
      r_shot     <= '0;
      r_per      <= '0;
      r_p1       <= '0;
      r_del      <= '0;
      r_p2       <= '0;
      r_step_idx <= '0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sh_per  <= cfg_period;
        r_sh_p1   <= cfg_p1wid;
        r_sh_del  <= cfg_delay;
        r_sh_p2   <= cfg_p2wid;
        r_sh_step <= cfg_step;
        r_sh_np   <= cfg_npoints;
        r_sh_ns   <= cfg_nshots;
        r_loaded  <= 1'b1;
        r_err     <= 1'b0;
      end
      if (abort) begin
        r_state   <= S_IDLE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && (r_loaded || w_accept)) begin
              r_state   <= S_ARMED;
              r_running <= 1'b1;
            end
          end
          S_ARMED: begin
            if (cycle_end) begin
              if (w_ok0) begin
                r_per      <= r_sh_per;
                r_p1       <= r_sh_p1;
                r_del      <= r_sh_del;
                r_p2       <= r_sh_p2;
                r_step_idx <= '0;
                r_shot     <= '0;
                r_state    <= S_RUN;
              end else begin
                r_err     <= 1'b1;
                r_state   <= S_IDLE;
                r_running <= 1'b0;
              end
            end
          end
          S_RUN: begin
            if (cycle_end) begin
              if (w_shots_done) begin
                r_shot <= '0;
                if (w_last) begin
                  r_state   <= S_IDLE;
                  r_running <= 1'b0;
                  r_done    <= 1'b1;
                end else if (w_ok_step) begin
                  r_step_idx <= r_step_idx + CW'(1);
                  r_del      <= w_del_step;
                end else begin
                  r_err     <= 1'b1;
                  r_state   <= S_IDLE;
                  r_running <= 1'b0;
                end
              end else begin
                r_shot <= w_shot_inc;
              end
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_ready = (r_state == S_IDLE);
  assign per       = r_per;
  assign p1wid     = r_p1;
  assign del       = r_del;
  assign p2wid     = r_p2;
  assign step_idx  = r_step_idx;
  assign running   = r_running;
  assign done      = r_done;
  assign err       = r_err;

endmodule
